jpeg_top: RTL and testbench
===========================

JPEG_TOP -- requirements
Module: jpeg_top

Interface
REQ-001 Parameter WIDTH, default 512, active pixels per line; SHALL be a multiple of 8.
REQ-002 Parameter HEIGHT, default 512, lines per frame; SHALL be a multiple of 8.
REQ-003 Parameter order SHALL be (WIDTH, HEIGHT), positional override allowed.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 pclk  input  1  camera pixel-clock pin; kept for pin compatibility, SHALL be unused (no logic clocked or sampled by it).
REQ-007 vsync  input  1  frame sync, high = frame start/abort.
REQ-008 href  input  1  line valid; each clk cycle with href=1 delivers one data byte.
REQ-009 data  input  8  RGB565 byte stream, high byte first.
REQ-010 out  output  huffman_pkg::HuffmanBus_t  packed struct {valid 1, data[31:0] right-aligned codeword, len[5:0] bit count, sop 1, eop 1}.

Function
REQ-011 Byte phase toggles per href=1 cycle and clears when href=0; an odd trailing byte at href fall SHALL be discarded.
REQ-012 Pixel = {hi,lo}; r5=[15:11], g6=[10:5], b5=[4:0]; expand by bit replication: r8={r5,r5[4:2]}, g8={g6,g6[5:4]}, b8={b5,b5[4:2]}.
REQ-013 Y = (77*r8 + 150*g8 + 29*b8) >> 8, unsigned 8 bits, truncating.
REQ-014 Column counter 0..WIDTH-1 advances per pixel; pixels with col>=WIDTH or row>=HEIGHT SHALL be ignored.
REQ-015 Row counter increments on each href falling edge (regardless of pixel count); column resets to 0.
REQ-016 Per block column k (WIDTH/8 entries) a 14-bit accumulator sums Y; cleared on the first pixel of each block in row%8==0.
REQ-017 Block completes at pixel with row%8==7 and col%8==7; avg = sum>>6; dc = avg-128 (signed 9-bit).
REQ-018 diff = dc - pred; pred <= dc; pred = 0 at frame start.
REQ-019 Category cat = bit length of |diff| (0..8).
REQ-020 Luminance DC codes: 0:00, 1:010, 2:011, 3:100, 4:101, 5:110, 6:1110, 7:11110, 8:111110.
REQ-021 Magnitude bits: low cat bits of diff if diff>=0, else of diff-1; none when cat=0.
REQ-022 out.data = {code, mag} right-aligned, zero-extended; out.len = codelen+cat (max 14).
REQ-023 out.valid SHALL pulse one cycle, at the 2nd clk edge after the edge capturing the completing pixel's low byte; all out fields zero when valid=0.
REQ-024 sop=1 with first block of frame; eop=1 with block at row HEIGHT-1, col WIDTH-1.
REQ-025 vsync=1 SHALL reset row, col, byte phase, pred and accumulator-clear state; an interrupted frame emits no eop.
REQ-026 Block order: left to right within each 8-row band, bands top to bottom; luminance only.

Reset
REQ-027 While rst_n=0 at a clk edge: out=0, counters=0, pred=0, byte phase=0, pipeline valid bits=0.
REQ-028 Reset mid-frame discards the partial frame; encoding resumes only after next vsync.

Verification
REQ-029 Hold rst_n=0 5 cycles -> out all zero; no valid for arbitrary href/data.
REQ-030 WIDTH=16,HEIGHT=8, all pixels 0xFFFF -> block0 data=0xF7F len=12 sop=1; block1 data=0x0 len=2 eop=1.
REQ-031 WIDTH=8,HEIGHT=8, all 0x0000 -> single output data=0x3E7F len=14 sop=1 eop=1.
REQ-032 WIDTH=8,HEIGHT=8, all 0x8410 (Y=130) -> data=0x0E len=5 sop=eop=1.
REQ-033 vsync pulse after 3 lines, then full 0xFFFF frame (16x8) -> first output sop=1 data=0xF7F (pred reset); exactly one eop.
REQ-034 Line with extra trailing byte before href fall -> identical outputs to clean stream.

Source files
------------

// File: rtl/jpeg_top.sv
// Luminance-only JPEG DC encoder: RGB565 camera bytes -> 8x8 block averages ->
// DC difference -> Huffman codeword (category code + magnitude bits) per block.
package huffman_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic [5:0]  len;
        logic        sop;
        logic        eop;
    } HuffmanBus_t;
endpackage

module jpeg_top #(
    parameter int WIDTH  = 512,
    parameter int HEIGHT = 512
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pclk,
    input  logic                     vsync,
    input  logic                     href,
    input  logic [7:0]               data,
    output huffman_pkg::HuffmanBus_t out
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(HEIGHT + 1);
    localparam int NB = WIDTH / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] WMAX  = CW'(WIDTH);
    localparam logic [CW-1:0] CLAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] HMAX  = RW'(HEIGHT);
    localparam logic [RW-1:0] RLAST = RW'(HEIGHT - 1);

    logic unused_pclk;
    assign unused_pclk = pclk;

    logic          armed, href_d, phase, first_blk;
    logic [7:0]    hi;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [13:0]   acc [NB];

    logic [7:0]    r8, g8, b8, y;
    logic [15:0]   y_sum;
    logic [BW-1:0] blk_idx;
    logic [13:0]   acc_base, acc_nxt;
    logic          pix_ok, blk_done, last_blk;

    always_comb begin
        r8       = {hi[7:3], hi[7:5]};
        g8       = {hi[2:0], data[7:5], hi[2:1]};
        b8       = {data[4:0], data[4:2]};
        y_sum    = 16'd77 * {8'b0, r8} + 16'd150 * {8'b0, g8} + 16'd29 * {8'b0, b8};
        y        = y_sum[15:8];
        blk_idx  = col[3 +: BW];
        pix_ok   = armed && !vsync && href && phase && (col < WMAX) && (row < HMAX);
        // first pixel of a block's top row restarts that column's sum
        acc_base = (row[2:0] == 3'd0 && col[2:0] == 3'd0) ? 14'd0 : acc[blk_idx];
        acc_nxt  = acc_base + {6'b0, y};
        blk_done = pix_ok && (row[2:0] == 3'd7) && (col[2:0] == 3'd7);
        last_blk = (row == RLAST) && (col == CLAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            armed     <= 1'b0;
            href_d    <= 1'b0;
            phase     <= 1'b0;
            col       <= '0;
            row       <= '0;
            first_blk <= 1'b0;
        end else if (vsync) begin
            armed     <= 1'b1;
            href_d    <= 1'b0;
            phase     <= 1'b0;
            col       <= '0;
            row       <= '0;
            first_blk <= 1'b1;
        end else begin
            href_d <= href;
            phase  <= href ? ~phase : 1'b0;
            if (href_d && !href) begin
                row <= (row == HMAX) ? row : row + 1'b1;
                col <= '0;
            end else if (href && phase && col != WMAX) begin
                col <= col + 1'b1;
            end
            if (blk_done) first_blk <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (href && !phase) hi <= data;
        if (pix_ok) acc[blk_idx] <= acc_nxt;
    end

    // 3-register pipeline: block dc, then diff/category, then codeword
    logic [1:0] vld_pipe;
    logic [8:0] s1_dc, pred, diff, s2_diff, absd, mag_src;
    logic       s1_sop, s1_eop, s2_sop, s2_eop;
    logic [3:0] cat, s2_cat;
    logic [5:0] code, codelen;

    always_comb begin
        diff = s1_dc - pred;
        absd = diff[8] ? (9'd0 - diff) : diff;
        cat  = 4'd0;
        for (int i = 0; i < 8; i++)
            if (absd[i]) cat = 4'(i + 1);
    end

    always_comb begin
        mag_src = s2_diff[8] ? (s2_diff - 9'd1) : s2_diff;
        code    = 6'b0;
        codelen = 6'd2;
        case (s2_cat)
            4'd0:    begin code = 6'b000000; codelen = 6'd2; end
            4'd1:    begin code = 6'b000010; codelen = 6'd3; end
            4'd2:    begin code = 6'b000011; codelen = 6'd3; end
            4'd3:    begin code = 6'b000100; codelen = 6'd3; end
            4'd4:    begin code = 6'b000101; codelen = 6'd3; end
            4'd5:    begin code = 6'b000110; codelen = 6'd3; end
            4'd6:    begin code = 6'b001110; codelen = 6'd4; end
            4'd7:    begin code = 6'b011110; codelen = 6'd5; end
            default: begin code = 6'b111110; codelen = 6'd6; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || vsync) begin
            vld_pipe <= 2'b0;
            pred     <= 9'd0;
        end else begin
            vld_pipe <= {vld_pipe[0], blk_done};
            if (vld_pipe[0]) pred <= s1_dc;
        end
    end

    always_ff @(posedge clk) begin
        s1_dc   <= {1'b0, acc_nxt[13:6]} - 9'd128;
        s1_sop  <= first_blk;
        s1_eop  <= last_blk;
        s2_diff <= diff;
        s2_cat  <= cat;
        s2_sop  <= s1_sop;
        s2_eop  <= s1_eop;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || vsync || !vld_pipe[1]) begin
            out <= '0;
        end else begin
            out <= '{valid: 1'b1,
                     data:  (32'(code) << s2_cat) |
                            (32'(mag_src) & ((32'd1 << s2_cat) - 32'd1)),
                     len:   codelen + 6'(s2_cat),
                     sop:   s2_sop,
                     eop:   s2_eop};
        end
    end
endmodule

// File: tb/tb_jpeg_top.sv
// Directed bench: two encoder instances (16x8 and 8x8) share one byte stream;
// each output is collected into a queue and checked against hand-computed codewords.
module tb_jpeg_top;
    import huffman_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0, pclk = 1'b0, vsync = 1'b0, href = 1'b0;
    logic [7:0] data = 8'h00;
    HuffmanBus_t o16, o8;

    int checks = 0, passes = 0;
    int cyc = 0, last_lo = 0, nz16 = 0, nz8 = 0;
    HuffmanBus_t q16[$], q8[$];
    int          c16[$];

    jpeg_top #(16, 8) u16 (.clk(clk), .rst_n(rst_n), .pclk(pclk), .vsync(vsync),
                           .href(href), .data(data), .out(o16));
    jpeg_top #(8, 8)  u8  (.clk(clk), .rst_n(rst_n), .pclk(pclk), .vsync(vsync),
                           .href(href), .data(data), .out(o8));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o16.valid) begin q16.push_back(o16); c16.push_back(cyc); end
        else if (o16 !== '0) nz16++;
        if (o8.valid) q8.push_back(o8);
        else if (o8 !== '0) nz8++;
    end

    function automatic HuffmanBus_t mk(input logic [31:0] d, input logic [5:0] l,
                                       input logic s, input logic e);
        HuffmanBus_t r;
        r.valid = 1'b1; r.data = d; r.len = l; r.sop = s; r.eop = e;
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic put_byte(input logic [7:0] b);
        href = 1'b1; data = b;
        tick(1);
    endtask

    task automatic send_line(input int npix, input logic [15:0] px, input bit extra);
        for (int i = 0; i < npix; i++) begin
            put_byte(px[15:8]);
            put_byte(px[7:0]);
            last_lo = cyc;
        end
        if (extra) put_byte(8'hA5);
        href = 1'b0; data = 8'h00;
        tick(2);
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1; tick(1);
        vsync = 1'b0; tick(1);
    endtask

    task automatic send_frame(input int npix, input int nlines, input logic [15:0] px,
                              input bit extra);
        for (int l = 0; l < nlines; l++) send_line(npix, px, extra);
        tick(6);
    endtask

    task automatic clear_q();
        q16.delete(); q8.delete(); c16.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            href = 1'($urandom); data = 8'($urandom); vsync = 1'($urandom);
            tick(1);
            checks++;
            if (o16 !== '0 || o8 !== '0) $display("FAIL reset_out cyc%0d: got %h / %h, need 0", i, o16, o8);
            else passes++;
        end
        href = 1'b0; vsync = 1'b0; data = 8'h00;
        rst_n = 1'b1;
        tick(3);
        checks++;
        if (q16.size() != 0 || q8.size() != 0)
            $display("FAIL reset_novalid: got %0d/%0d outputs, need 0", q16.size(), q8.size());
        else passes++;
    endtask

    task automatic test_reset_midframe();
        clear_q();
        vsync_pulse();
        for (int l = 0; l < 4; l++) send_line(16, 16'hFFFF, 1'b0);
        rst_n = 1'b0; tick(2); rst_n = 1'b1;
        send_frame(16, 8, 16'hFFFF, 1'b0);
        checks++;
        if (q16.size() != 0 || q8.size() != 0)
            $display("FAIL reset_midframe: got %0d/%0d outputs without vsync, need 0", q16.size(), q8.size());
        else passes++;
    endtask

    task automatic test_white();
        clear_q();
        vsync_pulse();
        send_frame(16, 8, 16'hFFFF, 1'b0);
        checks++;
        if (q16.size() != 2) $display("FAIL white16_count: got %0d, need 2", q16.size());
        else begin
            passes++;
            checks++;
            if (q16[0] !== mk(32'hF7F, 6'd12, 1'b1, 1'b0)) $display("FAIL white16_blk0: got %h, need %h", q16[0], mk(32'hF7F, 6'd12, 1'b1, 1'b0));
            else passes++;
            checks++;
            if (q16[1] !== mk(32'h0, 6'd2, 1'b0, 1'b1)) $display("FAIL white16_blk1: got %h, need %h", q16[1], mk(32'h0, 6'd2, 1'b0, 1'b1));
            else passes++;
            checks++;
            if (c16[1] != last_lo + 2) $display("FAIL white16_latency: got cycle %0d, need %0d", c16[1], last_lo + 2);
            else passes++;
        end
        checks++;
        if (q8.size() != 1 || q8[0] !== mk(32'hF7F, 6'd12, 1'b1, 1'b1))
            $display("FAIL white8: got %0d outputs first %h, need 1 of %h", q8.size(), (q8.size() > 0) ? q8[0] : '0, mk(32'hF7F, 6'd12, 1'b1, 1'b1));
        else passes++;
    endtask

    task automatic test_black();
        clear_q();
        vsync_pulse();
        send_frame(8, 8, 16'h0000, 1'b0);
        checks++;
        if (q8.size() != 1 || q8[0] !== mk(32'h3E7F, 6'd14, 1'b1, 1'b1))
            $display("FAIL black8: got %0d outputs first %h, need 1 of %h", q8.size(), (q8.size() > 0) ? q8[0] : '0, mk(32'h3E7F, 6'd14, 1'b1, 1'b1));
        else passes++;
        checks++;
        if (q16.size() != 1 || q16[0] !== mk(32'h3E7F, 6'd14, 1'b1, 1'b0))
            $display("FAIL black16: got %0d outputs first %h, need 1 of %h", q16.size(), (q16.size() > 0) ? q16[0] : '0, mk(32'h3E7F, 6'd14, 1'b1, 1'b0));
        else passes++;
    endtask

    task automatic test_gray();
        clear_q();
        vsync_pulse();
        send_frame(8, 8, 16'h8410, 1'b0);
        checks++;
        if (q8.size() != 1 || q8[0] !== mk(32'h0E, 6'd5, 1'b1, 1'b1))
            $display("FAIL gray8: got %0d outputs first %h, need 1 of %h", q8.size(), (q8.size() > 0) ? q8[0] : '0, mk(32'h0E, 6'd5, 1'b1, 1'b1));
        else passes++;
    endtask

    task automatic test_vsync_abort();
        int neop;
        clear_q();
        vsync_pulse();
        for (int l = 0; l < 3; l++) send_line(16, 16'hFFFF, 1'b0);
        vsync_pulse();
        // last line stops halfway, so block 0 is emitted and pred becomes nonzero
        for (int l = 0; l < 7; l++) send_line(16, 16'hFFFF, 1'b0);
        send_line(8, 16'hFFFF, 1'b0);
        tick(6);
        vsync_pulse();
        send_frame(16, 8, 16'hFFFF, 1'b0);
        checks++;
        if (q16.size() != 3) $display("FAIL abort_count: got %0d, need 3", q16.size());
        else begin
            passes++;
            checks++;
            if (q16[0] !== mk(32'hF7F, 6'd12, 1'b1, 1'b0)) $display("FAIL abort_partial: got %h, need %h", q16[0], mk(32'hF7F, 6'd12, 1'b1, 1'b0));
            else passes++;
            checks++;
            if (q16[1] !== mk(32'hF7F, 6'd12, 1'b1, 1'b0)) $display("FAIL abort_pred_reset: got %h, need %h", q16[1], mk(32'hF7F, 6'd12, 1'b1, 1'b0));
            else passes++;
        end
        neop = 0;
        foreach (q16[i]) if (q16[i].eop) neop++;
        checks++;
        if (neop != 1) $display("FAIL abort_eop_count: got %0d, need 1", neop);
        else passes++;
    endtask

    task automatic test_trailing_byte();
        clear_q();
        vsync_pulse();
        send_frame(16, 8, 16'hFFFF, 1'b1);
        checks++;
        if (q16.size() != 2 || q16[0] !== mk(32'hF7F, 6'd12, 1'b1, 1'b0) || q16[1] !== mk(32'h0, 6'd2, 1'b0, 1'b1))
            $display("FAIL trailing16: got %0d outputs first %h, need 2 starting %h", q16.size(), (q16.size() > 0) ? q16[0] : '0, mk(32'hF7F, 6'd12, 1'b1, 1'b0));
        else passes++;
    endtask

    task automatic test_back_to_back();
        clear_q();
        vsync_pulse();
        send_frame(8, 8, 16'h8410, 1'b0);
        vsync_pulse();
        send_frame(8, 8, 16'h0000, 1'b0);
        checks++;
        if (q8.size() != 2 || q8[0] !== mk(32'h0E, 6'd5, 1'b1, 1'b1) || q8[1] !== mk(32'h3E7F, 6'd14, 1'b1, 1'b1))
            $display("FAIL b2b8: got %0d outputs last %h, need 2 ending %h", q8.size(), (q8.size() > 0) ? q8[q8.size()-1] : '0, mk(32'h3E7F, 6'd14, 1'b1, 1'b1));
        else passes++;
        checks++;
        if (nz16 != 0 || nz8 != 0) $display("FAIL idle_zero: got %0d/%0d nonzero idle cycles, need 0", nz16, nz8);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_reset_midframe();
        test_white();
        test_black();
        test_gray();
        test_vsync_abort();
        test_trailing_byte();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
